// File: rtl/switch_button_pkg.sv
// Shared constants for the switch/button input peripheral.
`timescale 1ns/1ps
package switch_button_pkg;

  localparam int unsigned NUM_SW  = 8;
  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned NUM_IN  = NUM_SW + NUM_BTN;
  localparam int unsigned DATA_W  = 16;

  localparam logic ADDR_STATE   = 1'b0;
  localparam logic ADDR_PENDING = 1'b1;

  // 1 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 100000;
  localparam int unsigned CNT_W_DEF           = 17;

endpackage

// File: rtl/switch_button_in_debounce.sv
// Per-input 2-flop synchroniser plus counter-based debouncer.
// o_rise_c/o_fall_c pulse on the same edge the stable value updates.
`timescale 1ns/1ps
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             w_diff;
  logic             w_expire;

  assign w_diff   = r_sync2 ^ r_stable;
  assign w_expire = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Two-flop synchroniser for the asynchronous raw input
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on expiry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (w_expire) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_stable = r_stable;
  assign o_rise_c = w_expire & r_sync2;
  assign o_fall_c = w_expire & ~r_sync2;

endmodule

// File: rtl/switch_button_in.sv
// Switch/button input port on the 4-way handshake bus.
// Optional pending/interrupt logic is built when SWITCH_BUTTON_IRQ_EN is defined.
`timescale 1ns/1ps
module switch_button_in
  import switch_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Address,
  input  logic [DATA_W-1:0]  dataIn,
  input  logic               Write,
  input  logic               Read,
  output logic [DATA_W-1:0]  dataOut,
  output logic               Ack,
  input  logic [NUM_SW-1:0]  Switch,
  input  logic [NUM_BTN-1:0] Button,
  output logic               Interrupt
);

  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_stable;
  logic [NUM_IN-1:0] w_rise_c;
  logic [NUM_IN-1:0] w_fall_c;
  logic [NUM_IN-1:0] w_pending;
  logic              w_rd_go;
  logic              w_wr_go;
  logic              w_unused;
  logic              r_ack;
  logic [DATA_W-1:0] r_data_out;

  assign w_raw   = {Button, Switch};
  assign w_rd_go = Read  & ~r_ack;
  assign w_wr_go = Write & ~r_ack;

  // One debouncer per input bit
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_bit
    input_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clock    (clock),
      .reset    (reset),
      .i_raw    (w_raw[gi]),
      .o_stable (w_stable[gi]),
      .o_rise_c (w_rise_c[gi]),
      .o_fall_c (w_fall_c[gi])
    );
  end

  // Acknowledge follows the request level one cycle later
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ack <= 1'b0;
    else        r_ack <= Read | Write;
  end

  // Capture read data once per request, hold until the next read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
    end else if (w_rd_go) begin
      r_data_out <= (Address == ADDR_PENDING) ? DATA_W'(w_pending) : DATA_W'(w_stable);
    end
  end

`ifdef SWITCH_BUTTON_IRQ_EN
  logic [NUM_IN-1:0] r_pending;
  logic [NUM_IN-1:0] w_set;
  logic [NUM_IN-1:0] w_clr;
  logic              r_interrupt;

  // Switches flag both edges, buttons flag presses only
  assign w_set = {w_rise_c[NUM_IN-1:NUM_SW], w_rise_c[NUM_SW-1:0] | w_fall_c[NUM_SW-1:0]};
  assign w_clr = (w_wr_go && (Address == ADDR_PENDING)) ? dataIn[NUM_IN-1:0] : '0;

  // Pending bits: write-1-to-clear, a same-cycle set event wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  // Level interrupt while anything is pending
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_interrupt <= 1'b0;
    else        r_interrupt <= |r_pending;
  end

  assign w_pending = r_pending;
  assign Interrupt = r_interrupt;
  assign w_unused  = ^{dataIn[DATA_W-1:NUM_IN], w_fall_c[NUM_IN-1:NUM_SW]};
`else
  assign w_pending = '0;
  assign Interrupt = 1'b0;
  assign w_unused  = ^{dataIn, w_rise_c, w_fall_c};
`endif

  assign Ack     = r_ack;
  assign dataOut = r_data_out;

endmodule

// File: tb/tb_switch_button_in.sv
// Bench for switch_button_in: directed scenarios plus random input/bus traffic,
// checked every cycle against a window-based reference model.
`timescale 1ns/1ps
module tb_switch_button_in;
  import switch_button_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 3;
`ifdef SWITCH_BUTTON_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic               Address;
  logic [DATA_W-1:0]  dataIn;
  logic               Write;
  logic               Read;
  logic [DATA_W-1:0]  dataOut;
  logic               Ack;
  logic [NUM_SW-1:0]  Switch;
  logic [NUM_BTN-1:0] Button;
  logic               Interrupt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;

  switch_button_in #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .Address   (Address),
    .dataIn    (dataIn),
    .Write     (Write),
    .Read      (Read),
    .dataOut   (dataOut),
    .Ack       (Ack),
    .Switch    (Switch),
    .Button    (Button),
    .Interrupt (Interrupt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an input's stable value flips once the last DB synchronised
  // samples all disagree with it; samples reach the debouncer two edges late.
  logic [DB:0][NUM_IN-1:0] m_hist;
  logic [NUM_IN-1:0]       m_stable;
  logic [NUM_IN-1:0]       m_pend;
  logic                    m_ack;
  logic                    m_irq;
  logic [DATA_W-1:0]       m_dout;

  function automatic logic [NUM_IN-1:0] f_next_stable(input logic [NUM_IN-1:0] st,
                                                      input logic [DB:0][NUM_IN-1:0] hist);
    logic [NUM_IN-1:0] nxt;
    nxt = st;
    for (int b = 0; b < int'(NUM_IN); b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int k = 1; k <= int'(DB); k++)
        if (hist[k][b] == st[b]) all_diff = 1'b0;
      if (all_diff) nxt[b] = ~st[b];
    end
    return nxt;
  endfunction

  function automatic logic [NUM_IN-1:0] f_next_pend(input logic [NUM_IN-1:0] pend,
                                                    input logic [NUM_IN-1:0] st,
                                                    input logic [NUM_IN-1:0] nst,
                                                    input logic [NUM_IN-1:0] clr);
    logic [NUM_IN-1:0] chg;
    logic [NUM_IN-1:0] set;
    chg = st ^ nst;
    for (int b = 0; b < int'(NUM_IN); b++)
      set[b] = (b < int'(NUM_SW)) ? chg[b] : (chg[b] & nst[b]);
    return IRQ_EN ? ((pend & ~clr) | set) : '0;
  endfunction

  logic [NUM_IN-1:0] m_clr;
  assign m_clr = (Write && !m_ack && Address) ? dataIn[NUM_IN-1:0] : '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_hist   <= '0;
      m_stable <= '0;
      m_pend   <= '0;
      m_ack    <= 1'b0;
      m_irq    <= 1'b0;
      m_dout   <= '0;
    end else begin
      m_hist   <= {m_hist[DB-1:0], {Button, Switch}};
      m_stable <= f_next_stable(m_stable, m_hist);
      m_pend   <= f_next_pend(m_pend, m_stable, f_next_stable(m_stable, m_hist), m_clr);
      m_ack    <= Read | Write;
      m_irq    <= |m_pend;
      if (Read && !m_ack) m_dout <= Address ? DATA_W'(m_pend) : DATA_W'(m_stable);
    end
  end

  // Every cycle: outputs against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("ack", 32'(Ack), 32'(m_ack));
      check("dout", 32'(dataOut), 32'(m_dout));
      check("irq", 32'(Interrupt), 32'(m_irq));
    end
  end

  // Wait for Ack to reach lvl; it must take exactly one cycle
  task automatic wait_ack(input logic lvl, input string tag);
    int cyc;
    cyc = 0;
    while (cyc < 8) begin
      @(negedge clock);
      cyc++;
      if (Ack == lvl) break;
    end
    if (Ack != lvl) cyc = 99;
    check(tag, 32'(cyc), 32'd1);
  endtask

  task automatic bus_read(input logic a, output logic [DATA_W-1:0] d);
    @(negedge clock);
    Address = a;
    Read    = 1'b1;
    wait_ack(1'b1, "rd_ack_rise");
    d    = dataOut;
    Read = 1'b0;
    wait_ack(1'b0, "rd_ack_fall");
  endtask

  task automatic bus_write(input logic a, input logic [DATA_W-1:0] d, input int hold);
    @(negedge clock);
    Address = a;
    dataIn  = d;
    Write   = 1'b1;
    wait_ack(1'b1, "wr_ack_rise");
    repeat (hold - 1) @(negedge clock);
    Write = 1'b0;
    wait_ack(1'b0, "wr_ack_fall");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DATA_W-1:0] rd;

  initial begin
    reset = 1'b0; Address = 1'b0; dataIn = '0; Write = 1'b0; Read = 1'b0;
    Switch = '0; Button = '0;
    repeat (3) @(negedge clock);
    reset  = 1'b1;
    chk_en = 1'b1;

    // 1: reset state and basic read
    check("rst_dout", 32'(dataOut), 32'h0);
    check("rst_irq", 32'(Interrupt), 32'h0);
    bus_read(ADDR_STATE, rd);
    check("t1_state", 32'(rd), 32'h0);

    // 2: Switch[3] rises; stable updates on the 6th edge after the change
    @(negedge clock);
    Switch[3] = 1'b1;
    repeat (5) @(negedge clock);
    Address = ADDR_STATE;
    Read    = 1'b1;
    wait_ack(1'b1, "t2_ack");
    check("t2_state_early", 32'(dataOut), 32'h0);
    Read = 1'b0;
    wait_ack(1'b0, "t2_ack_fall");
    bus_read(ADDR_STATE, rd);
    check("t2_state", 32'(rd), 32'h0008);
    bus_read(ADDR_PENDING, rd);
    check("t2_pend", 32'(rd), IRQ_EN ? 32'h0008 : 32'h0);
    check("t2_irq", 32'(Interrupt), 32'(IRQ_EN));
    Switch[3] = 1'b0;
    repeat (10) @(negedge clock);
    bus_write(ADDR_PENDING, 16'h0008, 1);
    bus_read(ADDR_STATE, rd);
    check("t2_state_clr", 32'(rd), 32'h0);

    // 3: fast toggling never debounces
    for (int i = 0; i < 10; i++) begin
      Switch[0] = ~Switch[0];
      repeat (2) @(negedge clock);
    end
    repeat (8) @(negedge clock);
    bus_read(ADDR_STATE, rd);
    check("t3_state", 32'(rd), 32'h0);
    bus_read(ADDR_PENDING, rd);
    check("t3_pend", 32'(rd), 32'h0);
    check("t3_irq", 32'(Interrupt), 32'h0);

    // 4: button press flags, release does not; held write clears once
    Button[2] = 1'b1;
    repeat (10) @(negedge clock);
    Button[2] = 1'b0;
    repeat (10) @(negedge clock);
    bus_read(ADDR_PENDING, rd);
    check("t4_pend", 32'(rd), IRQ_EN ? 32'h0400 : 32'h0);
    bus_write(ADDR_PENDING, 16'hE400, 5);
    bus_read(ADDR_PENDING, rd);
    check("t4_pend_clr", 32'(rd), 32'h0);
    check("t4_irq", 32'(Interrupt), 32'h0);
    Button[1] = 1'b1;
    repeat (2) @(negedge clock);
    bus_write(ADDR_PENDING, 16'h0600, 8);
    bus_read(ADDR_PENDING, rd);
    check("t4_hold_once", 32'(rd), IRQ_EN ? 32'h0200 : 32'h0);
    Button[1] = 1'b0;
    repeat (8) @(negedge clock);
    bus_write(ADDR_PENDING, 16'h0200, 1);

    // 5: set and W1C on the same edge: set wins
    @(negedge clock);
    Button[0] = 1'b1;
    repeat (5) @(negedge clock);
    Address = ADDR_PENDING;
    dataIn  = 16'h0100;
    Write   = 1'b1;
    wait_ack(1'b1, "t5_ack");
    Write = 1'b0;
    wait_ack(1'b0, "t5_ack_fall");
    bus_read(ADDR_PENDING, rd);
    check("t5_pend", 32'(rd), IRQ_EN ? 32'h0100 : 32'h0);
    check("t5_irq", 32'(Interrupt), 32'(IRQ_EN));

    // 6: asynchronous reset in the middle of a read
    Switch[5] = 1'b1;
    @(negedge clock);
    Address = ADDR_STATE;
    Read    = 1'b1;
    @(negedge clock);
    check("t6_ack_pre", 32'(Ack), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t6_ack_rst", 32'(Ack), 32'h0);
    check("t6_dout_rst", 32'(dataOut), 32'h0);
    check("t6_irq_rst", 32'(Interrupt), 32'h0);
    @(negedge clock);
    Read = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    bus_read(ADDR_STATE, rd);
    check("t6_state_after", 32'(rd), 32'h0);
    repeat (10) @(negedge clock);
    bus_read(ADDR_STATE, rd);
    check("t6_state_held", 32'(rd), 32'h0120);
    bus_read(ADDR_PENDING, rd);
    check("t6_pend_held", 32'(rd), IRQ_EN ? 32'h0120 : 32'h0);
    Button[0] = 1'b0;

    // Random inputs, glitches and bus traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          Switch = Switch ^ 8'(1 << $urandom_range(0, 7));
          repeat ($urandom_range(1, 7)) @(negedge clock);
        end
        1: begin
          Button = Button ^ 5'(1 << $urandom_range(0, 4));
          repeat ($urandom_range(1, 7)) @(negedge clock);
        end
        2: begin
          bus_read(1'($urandom_range(0, 1)), rd);
          check("rnd_rd", 32'(rd), 32'(m_dout));
        end
        default: bus_write(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 3));
      endcase
    end

    repeat (10) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
